// File: rtl/fwd_hazard_if.sv
// Bundle between the ID/EX stage and the forwarding/hazard unit: EXE tag,
// source operands and pipeline control in, operand-mux selects and stall out.
interface fwd_hazard_if #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 2
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic                      adv_i;
    logic                      exe_valid_i;
    logic                      exe_flush_i;
    logic                      exe_we_i;
    logic [REG_AW-1:0]         exe_rd_i;
    logic [SELW-1:0]           exe_rdy_stage_i;
    logic [NUM_SRC*REG_AW-1:0] exe_src_i;
    logic [NUM_SRC-1:0]        exe_src_used_i;
    logic [NUM_SRC*SELW-1:0]   src_sel_o;
    logic                      stall_o;
    logic [15:0]               stall_cnt_o;

    modport master (
        output adv_i, exe_valid_i, exe_flush_i, exe_we_i, exe_rd_i,
               exe_rdy_stage_i, exe_src_i, exe_src_used_i,
        input  src_sel_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  adv_i, exe_valid_i, exe_flush_i, exe_we_i, exe_rd_i,
               exe_rdy_stage_i, exe_src_i, exe_src_used_i,
        output src_sel_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Keeps the destination tags of the last
// DEPTH instructions that left EXE in a shift register (stage 1 = MEM) and,
// per EXE source operand, selects the youngest matching producer's stage or
// raises a stall when that producer's result is not yet forwardable.
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 2,
    localparam int SELW   = $clog2(DEPTH + 1)
) (
    input logic         clk_i,
    input logic         rst_i,
    fwd_hazard_if.slave bus
);

    // Ready stage of 0 means "next stage"; anything beyond the tracked depth
    // is capped at the last stage, where the register file takes over.
    function automatic logic [SELW-1:0] clamp_rdy(input logic [SELW-1:0] r);
        logic [SELW-1:0] c;
        c = r;
        if (r == '0) begin
            c = SELW'(1);
        end else if (int'(r) > DEPTH) begin
            c = SELW'(DEPTH);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        logic [15:0] n;
        n = c;
        if (c != 16'hFFFF) begin
            n = c + 16'd1;
        end
        return n;
    endfunction

    logic                    v_p  [1:DEPTH];
    logic                    we_p [1:DEPTH];
    logic [REG_AW-1:0]       rd_p [1:DEPTH];
    logic [SELW-1:0]         rs_p [1:DEPTH];
    logic [15:0]             stall_cnt;
    logic [NUM_SRC-1:0]      hazard;
    logic [NUM_SRC*SELW-1:0] src_sel;
    logic                    live;
    logic                    stall;
    logic                    issue;

    // Per source: scan from stage 1 outward so the youngest producer wins.
    always_comb begin
        logic hit;
        src_sel = '0;
        hazard  = '0;
        hit     = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            hit = 1'b0;
            for (int k = 1; k <= DEPTH; k++) begin
                if (!hit && v_p[k] && we_p[k] && (rd_p[k] != '0) &&
                    (rd_p[k] == bus.exe_src_i[s*REG_AW +: REG_AW])) begin
                    hit = 1'b1;
                    if (bus.exe_src_used_i[s]) begin
                        if (SELW'(k) >= rs_p[k]) begin
                            src_sel[s*SELW +: SELW] = SELW'(k);
                        end else begin
                            hazard[s] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign live  = bus.exe_valid_i & ~bus.exe_flush_i;
    assign stall = live & (|hazard);
    assign issue = live & ~stall;

    // Control: valid bits shift with the pipeline; stall cycles are counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k <= DEPTH; k++) begin
                v_p[k] <= 1'b0;
            end
            stall_cnt <= '0;
        end else if (bus.adv_i) begin
            v_p[1] <= issue;
            for (int k = 2; k <= DEPTH; k++) begin
                v_p[k] <= v_p[k-1];
            end
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // Tag payload: qualified by v_p, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (bus.adv_i) begin
            we_p[1] <= bus.exe_we_i;
            rd_p[1] <= bus.exe_rd_i;
            rs_p[1] <= clamp_rdy(bus.exe_rdy_stage_i);
            for (int k = 2; k <= DEPTH; k++) begin
                we_p[k] <= we_p[k-1];
                rd_p[k] <= rd_p[k-1];
                rs_p[k] <= rs_p[k-1];
            end
        end
    end

    assign bus.src_sel_o   = src_sel;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (DEPTH 2, 4 and 31) driven with
// directed vectors; expected outputs are queued by the stimulus process and
// checked by an independent monitor on the falling edge.
module tb_fwd_hazard_unit;

    typedef struct {
        int          d;
        logic [5:0]  s0;
        logic [5:0]  s1;
        logic        st;
        logic [15:0] cnt;
        string       nm;
    } exp_t;

    logic       clk;
    logic       rst  [3];
    logic       adv  [3];
    logic       vld  [3];
    logic       fl   [3];
    logic       we   [3];
    logic [4:0] rd   [3];
    logic [4:0] s0   [3];
    logic [4:0] s1   [3];
    logic [5:0] rdy  [3];
    logic [1:0] used [3];

    exp_t q[$];
    int   n_vec;
    int   n_bad;

    fwd_hazard_if #(.DEPTH(2))  b2 ();
    fwd_hazard_if #(.DEPTH(4))  b4 ();
    fwd_hazard_if #(.DEPTH(31)) b31 ();

    fwd_hazard_unit #(.DEPTH(2))  u2  (.clk_i(clk), .rst_i(rst[0]), .bus(b2));
    fwd_hazard_unit #(.DEPTH(4))  u4  (.clk_i(clk), .rst_i(rst[1]), .bus(b4));
    fwd_hazard_unit #(.DEPTH(31)) u31 (.clk_i(clk), .rst_i(rst[2]), .bus(b31));

    assign b2.adv_i           = adv[0];
    assign b2.exe_valid_i     = vld[0];
    assign b2.exe_flush_i     = fl[0];
    assign b2.exe_we_i        = we[0];
    assign b2.exe_rd_i        = rd[0];
    assign b2.exe_rdy_stage_i = rdy[0][1:0];
    assign b2.exe_src_i       = {s1[0], s0[0]};
    assign b2.exe_src_used_i  = used[0];

    assign b4.adv_i           = adv[1];
    assign b4.exe_valid_i     = vld[1];
    assign b4.exe_flush_i     = fl[1];
    assign b4.exe_we_i        = we[1];
    assign b4.exe_rd_i        = rd[1];
    assign b4.exe_rdy_stage_i = rdy[1][2:0];
    assign b4.exe_src_i       = {s1[1], s0[1]};
    assign b4.exe_src_used_i  = used[1];

    assign b31.adv_i           = adv[2];
    assign b31.exe_valid_i     = vld[2];
    assign b31.exe_flush_i     = fl[2];
    assign b31.exe_we_i        = we[2];
    assign b31.exe_rd_i        = rd[2];
    assign b31.exe_rdy_stage_i = rdy[2][4:0];
    assign b31.exe_src_i       = {s1[2], s0[2]};
    assign b31.exe_src_used_i  = used[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input int d, input logic v, input logic w,
                          input logic [4:0] r, input logic [5:0] rs,
                          input logic [4:0] a, input logic [4:0] b,
                          input logic [1:0] u);
        vld[d]  = v;
        we[d]   = w;
        rd[d]   = r;
        rdy[d]  = rs;
        s0[d]   = a;
        s1[d]   = b;
        used[d] = u;
        fl[d]   = 1'b0;
        adv[d]  = 1'b1;
    endtask

    task automatic expect_out(input int d, input logic [5:0] a, input logic [5:0] b,
                              input logic st, input logic [15:0] c, input string nm);
        exp_t e;
        e.d   = d;
        e.s0  = a;
        e.s1  = b;
        e.st  = st;
        e.cnt = c;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    exp_t        m_e;
    logic [5:0]  m_s0;
    logic [5:0]  m_s1;
    logic        m_st;
    logic [15:0] m_cnt;

    // Monitor: every queued expectation is checked at the next falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.d)
                0: begin
                    m_s0 = 6'(b2.src_sel_o[1:0]);
                    m_s1 = 6'(b2.src_sel_o[3:2]);
                    m_st = b2.stall_o;
                    m_cnt = b2.stall_cnt_o;
                end
                1: begin
                    m_s0 = 6'(b4.src_sel_o[2:0]);
                    m_s1 = 6'(b4.src_sel_o[5:3]);
                    m_st = b4.stall_o;
                    m_cnt = b4.stall_cnt_o;
                end
                default: begin
                    m_s0 = 6'(b31.src_sel_o[4:0]);
                    m_s1 = 6'(b31.src_sel_o[9:5]);
                    m_st = b31.stall_o;
                    m_cnt = b31.stall_cnt_o;
                end
            endcase
            n_vec++;
            if (m_s0 !== m_e.s0 || m_s1 !== m_e.s1 || m_st !== m_e.st || m_cnt !== m_e.cnt) begin
                n_bad++;
                $display("FAIL %s (dut%0d): got sel=%0d,%0d stall=%0b cnt=%h, want sel=%0d,%0d stall=%0b cnt=%h",
                         m_e.nm, m_e.d, m_s0, m_s1, m_st, m_cnt, m_e.s0, m_e.s1, m_e.st, m_e.cnt);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int d = 0; d < 3; d++) begin
            set_in(d, 1'b0, 1'b0, 5'd0, 6'd1, 5'd0, 5'd0, 2'b00);
            rst[d] = 1'b1;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0;
            set_in(d, 1'b1, 1'b0, 5'd0, 6'd1, 5'd1, 5'd2, 2'b11);
            expect_out(d, 6'd0, 6'd0, 1'b0, 16'd0, "reset_state");
        end
        tick();
        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 1'b0, 5'd0, 6'd1, 5'd0, 5'd0, 2'b00);
        tick();

        // DEPTH=2: ALU forwarding from MEM, WB, then register file
        set_in(0, 1'b1, 1'b1, 5'd5, 6'd1, 5'd0, 5'd0, 2'b00);
        expect_out(0, 6'd0, 6'd0, 1'b0, 16'd0, "alu_producer");
        tick();
        set_in(0, 1'b1, 1'b1, 5'd6, 6'd1, 5'd5, 5'd5, 2'b11);
        expect_out(0, 6'd1, 6'd1, 1'b0, 16'd0, "fwd_mem");
        tick();
        set_in(0, 1'b1, 1'b0, 5'd0, 6'd1, 5'd5, 5'd0, 2'b01);
        expect_out(0, 6'd2, 6'd0, 1'b0, 16'd0, "fwd_wb");
        tick();
        set_in(0, 1'b1, 1'b0, 5'd0, 6'd1, 5'd5, 5'd5, 2'b11);
        expect_out(0, 6'd0, 6'd0, 1'b0, 16'd0, "fwd_regfile");
        tick();

        // Load-use: one stall, then WB forward
        set_in(0, 1'b1, 1'b1, 5'd7, 6'd2, 5'd0, 5'd0, 2'b00);
        tick();
        set_in(0, 1'b1, 1'b1, 5'd8, 6'd1, 5'd7, 5'd0, 2'b01);
        expect_out(0, 6'd0, 6'd0, 1'b1, 16'd0, "loaduse_stall");
        tick();
        expect_out(0, 6'd2, 6'd0, 1'b0, 16'd1, "loaduse_wb");
        tick();

        // Two producers of x9: youngest wins; x0 never forwards
        set_in(0, 1'b1, 1'b1, 5'd9, 6'd1, 5'd0, 5'd0, 2'b00);
        tick();
        tick();
        set_in(0, 1'b1, 1'b0, 5'd0, 6'd1, 5'd9, 5'd9, 2'b11);
        expect_out(0, 6'd1, 6'd1, 1'b0, 16'd1, "youngest_wins");
        tick();
        set_in(0, 1'b1, 1'b1, 5'd0, 6'd2, 5'd0, 5'd0, 2'b00);
        tick();
        tick();
        set_in(0, 1'b1, 1'b0, 5'd0, 6'd1, 5'd0, 5'd0, 2'b11);
        expect_out(0, 6'd0, 6'd0, 1'b0, 16'd1, "x0_ignored");
        tick();

        // Unused source, frozen pipeline, flush with hazard
        set_in(0, 1'b1, 1'b1, 5'd10, 6'd2, 5'd0, 5'd0, 2'b00);
        tick();
        set_in(0, 1'b1, 1'b1, 5'd11, 6'd1, 5'd3, 5'd10, 2'b01);
        adv[0] = 1'b0;
        expect_out(0, 6'd0, 6'd0, 1'b0, 16'd1, "unused_src");
        tick();
        set_in(0, 1'b1, 1'b1, 5'd11, 6'd1, 5'd3, 5'd10, 2'b11);
        adv[0] = 1'b0;
        expect_out(0, 6'd0, 6'd0, 1'b1, 16'd1, "frozen_stall");
        tick();
        set_in(0, 1'b1, 1'b1, 5'd11, 6'd1, 5'd3, 5'd10, 2'b11);
        fl[0] = 1'b1;
        expect_out(0, 6'd0, 6'd0, 1'b0, 16'd1, "flush_nostall");
        tick();
        set_in(0, 1'b1, 1'b0, 5'd0, 6'd1, 5'd11, 5'd10, 2'b11);
        expect_out(0, 6'd0, 6'd2, 1'b0, 16'd1, "flush_bubble");
        tick();

        // Ready stage 0 behaves as 1
        set_in(0, 1'b1, 1'b1, 5'd17, 6'd0, 5'd0, 5'd0, 2'b00);
        tick();
        set_in(0, 1'b1, 1'b0, 5'd0, 6'd1, 5'd17, 5'd0, 2'b01);
        expect_out(0, 6'd1, 6'd0, 1'b0, 16'd1, "rdy0_as_1");
        tick();

        // Reset during a stall
        set_in(0, 1'b1, 1'b1, 5'd12, 6'd2, 5'd0, 5'd0, 2'b00);
        tick();
        set_in(0, 1'b1, 1'b0, 5'd0, 6'd1, 5'd12, 5'd0, 2'b01);
        expect_out(0, 6'd0, 6'd0, 1'b1, 16'd1, "stall_before_rst");
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        expect_out(0, 6'd0, 6'd0, 1'b0, 16'd0, "after_rst");
        tick();

        // Ready stage beyond DEPTH clamps to DEPTH
        set_in(0, 1'b1, 1'b1, 5'd18, 6'd3, 5'd0, 5'd0, 2'b00);
        tick();
        set_in(0, 1'b1, 1'b0, 5'd0, 6'd1, 5'd18, 5'd0, 2'b01);
        expect_out(0, 6'd0, 6'd0, 1'b1, 16'd0, "clamp_stall");
        tick();
        expect_out(0, 6'd2, 6'd0, 1'b0, 16'd1, "clamp_fwd");
        tick();
        set_in(0, 1'b0, 1'b0, 5'd0, 6'd1, 5'd0, 5'd0, 2'b00);

        // DEPTH=4: ready stage 3, two stalls with a freeze in between
        set_in(1, 1'b1, 1'b1, 5'd14, 6'd3, 5'd0, 5'd0, 2'b00);
        tick();
        set_in(1, 1'b1, 1'b1, 5'd15, 6'd1, 5'd14, 5'd14, 2'b11);
        expect_out(1, 6'd0, 6'd0, 1'b1, 16'd0, "d4_stall1");
        tick();
        adv[1] = 1'b0;
        expect_out(1, 6'd0, 6'd0, 1'b1, 16'd1, "d4_stall2");
        tick();
        for (int i = 0; i < 5; i++) begin
            expect_out(1, 6'd0, 6'd0, 1'b1, 16'd1, "d4_frozen");
            tick();
        end
        adv[1] = 1'b1;
        expect_out(1, 6'd0, 6'd0, 1'b1, 16'd1, "d4_resume");
        tick();
        expect_out(1, 6'd3, 6'd3, 1'b0, 16'd2, "d4_fwd3");
        tick();

        // DEPTH=4: ready stage 7 clamps to 4 -> three stalls then select 4
        set_in(1, 1'b1, 1'b1, 5'd16, 6'd7, 5'd0, 5'd0, 2'b00);
        tick();
        set_in(1, 1'b1, 1'b0, 5'd0, 6'd1, 5'd16, 5'd0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            expect_out(1, 6'd0, 6'd0, 1'b1, 16'(2 + i), "d4_clamp_stall");
            tick();
        end
        expect_out(1, 6'd4, 6'd0, 1'b0, 16'd5, "d4_clamp_fwd");
        tick();

        // DEPTH=4: reset with the pipeline frozen still clears state
        set_in(1, 1'b1, 1'b1, 5'd20, 6'd3, 5'd0, 5'd0, 2'b00);
        tick();
        set_in(1, 1'b1, 1'b0, 5'd0, 6'd1, 5'd20, 5'd0, 2'b01);
        expect_out(1, 6'd0, 6'd0, 1'b1, 16'd5, "d4_pre_rst");
        adv[1] = 1'b0;
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        expect_out(1, 6'd0, 6'd0, 1'b0, 16'd0, "d4_rst_frozen");
        tick();
        set_in(1, 1'b0, 1'b0, 5'd0, 6'd1, 5'd0, 5'd0, 2'b00);

        // DEPTH=31: self-dependent producer, ready stage 31 -> 30 stalls per 31 cycles
        set_in(2, 1'b1, 1'b1, 5'd13, 6'd31, 5'd13, 5'd0, 2'b01);
        expect_out(2, 6'd0, 6'd0, 1'b0, 16'd0, "deep_issue");
        tick();
        for (int c = 1; c <= 30; c++) begin
            expect_out(2, 6'd0, 6'd0, 1'b1, 16'(c - 1), "deep_stall");
            tick();
        end
        expect_out(2, 6'd31, 6'd0, 1'b0, 16'd30, "deep_fwd31");
        tick();
        repeat (31 * 2200 - 1) tick();
        expect_out(2, 6'd31, 6'd0, 1'b0, 16'hFFFF, "cnt_saturated");
        tick();
        expect_out(2, 6'd0, 6'd0, 1'b1, 16'hFFFF, "cnt_sat_stall");
        tick();
        expect_out(2, 6'd0, 6'd0, 1'b1, 16'hFFFF, "cnt_sat_hold");
        tick();

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
